// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: widths, function classes,
// the divide opcode and the scheduler state encoding.
package alu_pkg;

    localparam int DATA_IN_W   = 16;
    localparam int ARITH_OUT_W = 32;
    localparam int LOGIC_OUT_W = 16;
    localparam int CMP_OUT_W   = 2;
    localparam int SHIFT_OUT_W = 17;

    typedef enum logic [1:0] {
        CLS_ARITH = 2'b00,
        CLS_LOGIC = 2'b01,
        CLS_CMP   = 2'b10,
        CLS_SHIFT = 2'b11
    } func_cls_t;

    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_RESP
    } sched_state_t;

endpackage

// File: rtl/alu_req_sched_rr_arb2.sv
// Two-request round-robin arbiter; one-hot grant, last-grant pointer moves on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last;

    // On contention the requester not granted last time wins.
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler in front of the registered ALU: accepts one command,
// issues it, captures the class-selected result and returns a tagged response.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int Data_In_WIDTH   = DATA_IN_W,
    parameter int Arith_Out_WIDTH = ARITH_OUT_W,
    parameter int Logic_Out_WIDTH = LOGIC_OUT_W,
    parameter int CMP_Out_WIDTH   = CMP_OUT_W,
    parameter int Shift_Out_WIDTH = SHIFT_OUT_W
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Req0_Valid,
    output logic                       Req0_Ready,
    input  logic [Data_In_WIDTH-1:0]   Req0_A,
    input  logic [Data_In_WIDTH-1:0]   Req0_B,
    input  logic [3:0]                 Req0_FUNC,
    input  logic                       Req1_Valid,
    output logic                       Req1_Ready,
    input  logic [Data_In_WIDTH-1:0]   Req1_A,
    input  logic [Data_In_WIDTH-1:0]   Req1_B,
    input  logic [3:0]                 Req1_FUNC,
    output logic [Data_In_WIDTH-1:0]   ALU_A,
    output logic [Data_In_WIDTH-1:0]   ALU_B,
    output logic [3:0]                 ALU_FUNC,
    input  logic [Arith_Out_WIDTH-1:0] Arith_OUT,
    input  logic [Logic_Out_WIDTH-1:0] Logic_OUT,
    input  logic [CMP_Out_WIDTH-1:0]   CMP_OUT,
    input  logic [Shift_Out_WIDTH-1:0] SHIFT_OUT,
    input  logic                       Arith_Flag,
    input  logic                       Logic_Flag,
    input  logic                       CMP_Flag,
    input  logic                       SHIFT_Flag,
    output logic                       Resp_Valid,
    input  logic                       Resp_Ready,
    output logic                       Resp_ID,
    output logic [Arith_Out_WIDTH-1:0] Resp_Data,
    output logic                       Resp_Err
);

    sched_state_t               state, state_nxt;
    logic [1:0]                 gnt;
    logic                       accept;
    logic                       win_id;
    logic [Data_In_WIDTH-1:0]   win_a, win_b;
    logic [3:0]                 win_func;
    logic                       div_zero;
    logic [Arith_Out_WIDTH-1:0] sel_data;
    logic [3:0]                 flags, flags_exp;
    logic                       flag_err;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RST),
        .req    ({Req1_Valid, Req0_Valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign Req0_Ready = (state == ST_IDLE) & gnt[0];
    assign Req1_Ready = (state == ST_IDLE) & gnt[1];
    assign accept     = Req0_Ready | Req1_Ready;
    assign Resp_Valid = (state == ST_RESP);

    always_comb begin
        win_id   = gnt[1];
        win_a    = win_id ? Req1_A    : Req0_A;
        win_b    = win_id ? Req1_B    : Req0_B;
        win_func = win_id ? Req1_FUNC : Req0_FUNC;
        div_zero = (win_func == FUNC_DIV) && (win_b == '0);
    end

    // ALU_FUNC still holds the issued command's function while in CAPT.
    always_comb begin
        sel_data = '0;
        case (func_cls_t'(ALU_FUNC[3:2]))
            CLS_ARITH: sel_data = Arith_OUT;
            CLS_LOGIC: sel_data = Arith_Out_WIDTH'(Logic_OUT);
            CLS_CMP:   sel_data = Arith_Out_WIDTH'(CMP_OUT);
            CLS_SHIFT: sel_data = Arith_Out_WIDTH'(SHIFT_OUT);
            default:   sel_data = '0;
        endcase
        flags     = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
        flags_exp = 4'b0001 << ALU_FUNC[3:2];
        flag_err  = (flags != flags_exp);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = div_zero ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = ST_RESP;
            ST_RESP:  if (Resp_Ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUNC  <= '0;
            Resp_ID   <= 1'b0;
            Resp_Data <= '0;
            Resp_Err  <= 1'b0;
        end else if (accept) begin
            Resp_ID <= win_id;
            // A divide by zero never reaches the ALU and responds straight away.
            if (div_zero) begin
                Resp_Data <= '0;
                Resp_Err  <= 1'b1;
            end else begin
                ALU_A    <= win_a;
                ALU_B    <= win_b;
                ALU_FUNC <= win_func;
            end
        end else if (state == ST_CAPT) begin
            Resp_Data <= sel_data;
            Resp_Err  <= flag_err;
        end
    end

endmodule

// File: tb/tb_alu_req_sched.sv
// Scoreboard bench for alu_req_sched with a behavioural ALU and scheduler model.
module tb_alu_req_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Req0_Valid = 1'b0, Req1_Valid = 1'b0;
    logic        Req0_Ready, Req1_Ready;
    logic [15:0] Req0_A = '0, Req0_B = '0, Req1_A = '0, Req1_B = '0;
    logic [3:0]  Req0_FUNC = '0, Req1_FUNC = '0;
    logic [15:0] ALU_A, ALU_B;
    logic [3:0]  ALU_FUNC;
    logic [31:0] Arith_OUT;
    logic [15:0] Logic_OUT;
    logic [1:0]  CMP_OUT;
    logic [16:0] SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        Resp_Valid;
    logic        Resp_Ready = 1'b0;
    logic        Resp_ID;
    logic [31:0] Resp_Data;
    logic        Resp_Err;

    alu_req_sched #(
        .Data_In_WIDTH   (16),
        .Arith_Out_WIDTH (32),
        .Logic_Out_WIDTH (16),
        .CMP_Out_WIDTH   (2),
        .Shift_Out_WIDTH (17)
    ) dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_FUNC(Req0_FUNC),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_FUNC(Req1_FUNC),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_ID(Resp_ID),
        .Resp_Data(Resp_Data), .Resp_Err(Resp_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        int unsigned inj;
        bit          has_lit;
        logic [31:0] lit;
    } cmd_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t q_exp[$];

    int checks = 0;
    int failures = 0;

    // Scheduler model: busy flag, edges left until the response shows, last grant.
    bit          busy = 1'b0;
    int          lat = 0;
    bit          model_last = 1'b1;
    int          hold_cnt = 0;
    logic [15:0] exp_a = '0, exp_b = '0;
    logic [3:0]  exp_f = '0;
    int unsigned inj_cur = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_arith(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (f[1:0])
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = (sb != 0) ? sa / sb : 0;
        endcase
        return 32'(r);
    endfunction

    function automatic logic [15:0] alu_logic(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        case (f[1:0])
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [1:0] alu_cmp(logic [15:0] a, logic [15:0] b);
        return {$signed(a) > $signed(b), a == b};
    endfunction

    function automatic logic [16:0] alu_shift(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f[1:0])
            2'd0:    return 17'(sa >>> 1);
            2'd1:    return {a, 1'b0};
            2'd2:    return 17'(sb >>> 1);
            default: return {b, 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] ref_result(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        case (f[3:2])
            2'b00:   return alu_arith(a, b, f);
            2'b01:   return {16'b0, alu_logic(a, b, f)};
            2'b10:   return {30'b0, alu_cmp(a, b)};
            default: return {15'b0, alu_shift(a, b, f)};
        endcase
    endfunction

    function automatic cmd_t mk(logic [15:0] a, logic [15:0] b, logic [3:0] f,
                                int unsigned inj, bit has_lit, logic [31:0] lit);
        cmd_t c;
        c.a = a; c.b = b; c.f = f; c.inj = inj; c.has_lit = has_lit; c.lit = lit;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.f = 4'($urandom_range(0, 15));
        c.a = 16'($urandom);
        c.b = 16'($urandom);
        if (c.f == 4'b0011 && $urandom_range(0, 2) == 0) c.b = '0;
        c.inj = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
        c.has_lit = 1'b0;
        c.lit = '0;
        return c;
    endfunction

    // Registered ALU stand-in; inj_cur optionally corrupts the class flags.
    always @(posedge CLK or negedge RST) begin
        logic [3:0] fl;
        if (!RST) begin
            Arith_OUT <= '0; Logic_OUT <= '0; CMP_OUT <= '0; SHIFT_OUT <= '0;
            {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} <= '0;
        end else begin
            Arith_OUT <= alu_arith(ALU_A, ALU_B, ALU_FUNC);
            Logic_OUT <= alu_logic(ALU_A, ALU_B, ALU_FUNC);
            CMP_OUT   <= alu_cmp(ALU_A, ALU_B);
            SHIFT_OUT <= alu_shift(ALU_A, ALU_B, ALU_FUNC);
            fl = 4'b0001 << ALU_FUNC[3:2];
            if (inj_cur == 1) fl = fl | (4'b0001 << 2'(ALU_FUNC[3:2] + 2'd1));
            if (inj_cur == 2) fl = '0;
            {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} <= fl;
        end
    end

    // Monitor: whenever a response is presented it must match the oldest expectation.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST && Resp_Valid) begin
                if (q_exp.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    chk("resp_id",   Resp_ID,   q_exp[0].id);
                    chk("resp_data", Resp_Data, q_exp[0].data);
                    chk("resp_err",  Resp_Err,  q_exp[0].err);
                    if (Resp_Ready) void'(q_exp.pop_front());
                end
            end
        end
    end

    // policy: 0 = Resp_Ready high, 1 = random, 2 = low for 5 response cycles
    task automatic step(input int policy);
        cmd_t c;
        exp_t e;
        logic w, er0, er1, ev;
        @(negedge CLK);
        Req0_Valid = (q0.size() != 0);
        if (Req0_Valid) begin
            Req0_A = q0[0].a; Req0_B = q0[0].b; Req0_FUNC = q0[0].f;
        end else begin
            Req0_A = 16'($urandom); Req0_B = 16'($urandom); Req0_FUNC = 4'($urandom);
        end
        Req1_Valid = (q1.size() != 0);
        if (Req1_Valid) begin
            Req1_A = q1[0].a; Req1_B = q1[0].b; Req1_FUNC = q1[0].f;
        end else begin
            Req1_A = 16'($urandom); Req1_B = 16'($urandom); Req1_FUNC = 4'($urandom);
        end
        ev = busy && (lat == 0);
        case (policy)
            0: Resp_Ready = 1'b1;
            1: Resp_Ready = 1'($urandom_range(0, 1));
            default: begin
                if (ev) begin
                    Resp_Ready = (hold_cnt >= 5);
                    hold_cnt++;
                end else begin
                    Resp_Ready = 1'b0;
                    hold_cnt = 0;
                end
            end
        endcase
        #1;
        er0 = !busy && Req0_Valid && (!Req1_Valid || model_last);
        er1 = !busy && Req1_Valid && (!Req0_Valid || !model_last);
        chk("req0_ready", Req0_Ready, er0);
        chk("req1_ready", Req1_Ready, er1);
        chk("resp_valid", Resp_Valid, ev);
        chk("alu_a", ALU_A, exp_a);
        chk("alu_b", ALU_B, exp_b);
        chk("alu_func", ALU_FUNC, exp_f);
        if (busy) begin
            if (lat == 0) begin
                if (Resp_Ready) busy = 1'b0;
            end else begin
                lat--;
            end
        end else if (er0 || er1) begin
            w = er1;
            c = w ? q1.pop_front() : q0.pop_front();
            model_last = w;
            e.id = w;
            if (c.f == 4'b0011 && c.b == '0) begin
                e.data = '0;
                e.err  = 1'b1;
                lat = 0;
            end else begin
                e.data = ref_result(c.a, c.b, c.f);
                e.err  = (c.inj != 0);
                lat = 2;
                exp_a = c.a; exp_b = c.b; exp_f = c.f;
                inj_cur = c.inj;
            end
            if (c.has_lit) e.data = c.lit;
            q_exp.push_back(e);
            busy = 1'b1;
        end
    endtask

    task automatic drain(input int policy);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !busy) && n < 400) begin
            step(policy);
            n++;
        end
        chk("drain_timeout", (n < 400), 1);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {Req0_Ready, Req1_Ready, ALU_A, ALU_B, ALU_FUNC,
                              Resp_Valid, Resp_ID, Resp_Data, Resp_Err}, 0);
        @(negedge CLK);
        RST = 1'b1;

        // Single requester, signed add
        q0.push_back(mk(16'hFFFA, 16'hFFE7, 4'b0000, 0, 1, 32'hFFFFFFE1));
        drain(0);

        // Continuous contention, alternate grants
        for (int unsigned i = 0; i < 4; i++) begin
            q0.push_back(mk(16'($urandom), 16'($urandom), 4'b0001, 0, 0, '0));
            q1.push_back(mk(16'h0005, 16'hFFF9, 4'b0010, 0, 1, 32'hFFFFFFDD));
        end
        drain(0);

        // Divide by zero from Req1
        q1.push_back(mk(16'h0032, 16'h0000, 4'b0011, 0, 1, 32'h0));
        drain(0);

        // Shift result held under back-pressure while Req1 waits
        q0.push_back(mk(16'h0003, 16'h000A, 4'b1111, 0, 1, 32'h00000014));
        q1.push_back(mk(16'h1234, 16'h0042, 4'b0100, 0, 0, '0));
        drain(2);

        // Extra Logic_Flag during an arithmetic op
        q0.push_back(mk(16'h0100, 16'h0001, 4'b0001, 1, 0, '0));
        q1.push_back(mk(16'h0007, 16'h0003, 4'b1000, 2, 0, '0));
        drain(1);

        // Reset while the command sits in CAPT
        q0.push_back(mk(16'h0011, 16'h0022, 4'b0000, 0, 0, '0));
        begin
            int n;
            n = 0;
            do begin
                step(0);
                n++;
            end while (!(busy && lat == 1) && n < 20);
            chk("capt_reach", (n < 20), 1);
        end
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("midop_reset", {Req0_Ready, Req1_Ready, ALU_A, ALU_B, ALU_FUNC,
                            Resp_Valid, Resp_ID, Resp_Data, Resp_Err}, 0);
        q_exp.delete();
        busy = 1'b0; lat = 0; model_last = 1'b1; inj_cur = 0;
        exp_a = '0; exp_b = '0; exp_f = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        q0.push_back(mk(16'h0001, 16'h0002, 4'b0000, 0, 1, 32'h00000003));
        q1.push_back(mk(16'h0004, 16'h0002, 4'b0011, 0, 1, 32'h00000002));
        drain(0);

        // Randomized batches
        for (int unsigned k = 0; k < 30; k++) begin
            for (int unsigned j = 0; j < $urandom_range(0, 3); j++) q0.push_back(rnd_cmd());
            for (int unsigned j = 0; j < $urandom_range(0, 3); j++) q1.push_back(rnd_cmd());
            drain(1);
        end

        repeat (3) step(0);
        chk("scoreboard_empty", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
